// File: rtl/mux_n_stream.sv
// N-channel valid/ready stream multiplexer with a registered output stage and a
// fixed-priority or round-robin arbiter. Define MUX_N_STREAM_SKID_EN to add a one-entry skid buffer.
module mux_n_stream #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned ARB_MODE = 0,
  localparam int unsigned SEL_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_sel_q, out_sel_d;
  logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;

  logic                load_en;
  logic                any_req;
  logic                xfer;
  logic [SEL_W-1:0]    grant_idx;
  logic [CHANNELS-1:0] grant;
  logic [WIDTH-1:0]    grant_data;

  // Channel index (base + off) reduced modulo CHANNELS; off is always < CHANNELS.
  function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] base,
                                                input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= CHANNELS) s = s - CHANNELS;
    return SEL_W'(s);
  endfunction

  // Arbiter: scan from the highest search position down so the first hit in
  // search order is the last one assigned.
  always_comb begin
    grant_idx = '0;
    grant     = '0;
    any_req   = |in_valid;
    if (ARB_MODE == 0) begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (in_valid[CHANNELS-1-k]) grant_idx = SEL_W'(CHANNELS - 1 - k);
      end
    end else begin
      for (int unsigned k = 0; k < CHANNELS; k++) begin
        if (in_valid[wrap_add(rr_ptr_q, CHANNELS - 1 - k)]) begin
          grant_idx = wrap_add(rr_ptr_q, CHANNELS - 1 - k);
        end
      end
    end
    grant[grant_idx] = any_req;
    grant_data       = in_data[grant_idx*WIDTH +: WIDTH];
  end

  assign xfer     = load_en & any_req;
  assign in_ready = grant & {CHANNELS{load_en & rst_n}};
  assign rr_ptr_d = xfer ? wrap_add(grant_idx, 1) : rr_ptr_q;

`ifdef MUX_N_STREAM_SKID_EN
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic             out_adv;

  // Accepting depends only on registered skid occupancy, never on out_ready.
  assign load_en = ~skid_valid_q & ~flush;
  assign out_adv = ~out_valid_q | out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_sel_d   = skid_sel_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_adv) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_sel_d    = skid_sel_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = xfer;
        if (xfer) begin
          out_data_d = grant_data;
          out_sel_d  = grant_idx;
        end
      end
    end else if (xfer) begin
      skid_valid_d = 1'b1;
      skid_data_d  = grant_data;
      skid_sel_d   = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_sel_q   <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_sel_q   <= skid_sel_d;
    end
  end
`else
  assign load_en = (~out_valid_q | out_ready) & ~flush;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load_en) begin
      out_valid_d = any_req;
      if (any_req) begin
        out_data_d = grant_data;
        out_sel_d  = grant_idx;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_n_stream.sv
// Scoreboard bench for mux_n_stream: one fixed-priority and one round-robin instance
// share stimulus; expected words are queued when driven and popped when produced.
module tb_mux_n_stream;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         flush = 1'b0;
  logic [127:0] in_data = '0;
  logic [3:0]   in_valid = '0;
  logic         out_ready = 1'b0;

  logic [3:0]   fp_in_ready, rr_in_ready;
  logic [31:0]  fp_out_data, rr_out_data;
  logic [1:0]   fp_out_sel, rr_out_sel;
  logic         fp_out_valid, rr_out_valid;

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } item_t;

  item_t sbq[$];
  item_t it;
  int    total = 0;
  int    bad = 0;

  always #5 clk = ~clk;

  mux_n_stream #(.WIDTH(32), .CHANNELS(4), .ARB_MODE(0)) u_fp (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(fp_in_ready), .out_data(fp_out_data), .out_sel(fp_out_sel),
    .out_valid(fp_out_valid), .out_ready(out_ready)
  );

  mux_n_stream #(.WIDTH(32), .CHANNELS(4), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(rr_in_ready), .out_data(rr_out_data), .out_sel(rr_out_sel),
    .out_valid(rr_out_valid), .out_ready(out_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [31:0] v);
    in_data[i*32 +: 32] = v;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = '0;
    out_ready = 1'b0;
    in_data = '0;
    sbq.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3;
    rst_n = 1'b0;
    in_valid = 4'hF;
    out_ready = 1'b1;
    tick();
    total++; if (fp_in_ready !== 4'h0) begin bad++;
      $display("FAIL reset_in_ready_fp got=%h exp=0", fp_in_ready); end
    total++; if (rr_in_ready !== 4'h0) begin bad++;
      $display("FAIL reset_in_ready_rr got=%h exp=0", rr_in_ready); end
    total++; if (fp_out_valid !== 1'b0) begin bad++;
      $display("FAIL reset_out_valid got=%b exp=0", fp_out_valid); end
    total++; if (fp_out_data !== 32'h0) begin bad++;
      $display("FAIL reset_out_data got=%h exp=0", fp_out_data); end
    total++; if (fp_out_sel !== 2'd0) begin bad++;
      $display("FAIL reset_out_sel got=%0d exp=0", fp_out_sel); end
    total++; if (rr_out_valid !== 1'b0) begin bad++;
      $display("FAIL reset_out_valid_rr got=%b exp=0", rr_out_valid); end
    in_valid = '0;
    rst_n = 1'b1;
  endtask

  task automatic test_priority();
    do_reset();
    out_ready = 1'b1;
    set_ch(1, 32'h11);
    set_ch(3, 32'h33);
    in_valid = 4'b1010;
    for (int c = 0; c < 3; c++) begin
      sbq.push_back('{sel: 2'd1, data: 32'h11});
      #1;
      total++; if (fp_in_ready !== 4'b0010) begin bad++;
        $display("FAIL prio_in_ready c=%0d got=%b exp=0010", c, fp_in_ready); end
      tick();
      it = sbq.pop_front();
      total++; if (fp_out_valid !== 1'b1 || fp_out_sel !== it.sel || fp_out_data !== it.data)
        begin bad++; $display("FAIL prio_out c=%0d got=%b/%0d/%h exp=1/%0d/%h", c,
        fp_out_valid, fp_out_sel, fp_out_data, it.sel, it.data); end
    end
    in_valid = '0;
  endtask

  task automatic test_round_robin();
    logic [3:0] er;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_ch(i, 32'hA0 + i);
    in_valid = 4'hF;
    for (int c = 0; c < 5; c++) begin
      sbq.push_back('{sel: 2'(c % 4), data: 32'hA0 + 32'(c % 4)});
      er = 4'b0001 << (c % 4);
      #1;
      total++; if (rr_in_ready !== er) begin bad++;
        $display("FAIL rr_in_ready c=%0d got=%b exp=%b", c, rr_in_ready, er); end
      tick();
      it = sbq.pop_front();
      total++; if (rr_out_valid !== 1'b1 || rr_out_sel !== it.sel || rr_out_data !== it.data)
        begin bad++; $display("FAIL rr_out c=%0d got=%b/%0d/%h exp=1/%0d/%h", c,
        rr_out_valid, rr_out_sel, rr_out_data, it.sel, it.data); end
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    logic [3:0] er;
    logic       skid;
`ifdef MUX_N_STREAM_SKID_EN
    skid = 1'b1;
`else
    skid = 1'b0;
`endif
    do_reset();
    out_ready = 1'b1;
    set_ch(2, 32'hDEAD);
    in_valid = 4'b0100;
    sbq.push_back('{sel: 2'd2, data: 32'hDEAD});
    tick();
    out_ready = 1'b0;
    set_ch(2, 32'hBEEF);
    for (int c = 0; c < 4; c++) begin
      er = (skid && c == 0) ? 4'b0100 : 4'b0000;
      #1;
      total++; if (fp_in_ready !== er) begin bad++;
        $display("FAIL bp_stall_in_ready c=%0d got=%b exp=%b", c, fp_in_ready, er); end
      if (er != 4'b0000) sbq.push_back('{sel: 2'd2, data: 32'hBEEF});
      tick();
      if (skid) in_valid = '0;
      total++; if (fp_out_valid !== 1'b1 || fp_out_data !== sbq[0].data || fp_out_sel !== 2'd2)
        begin bad++; $display("FAIL bp_stall_out c=%0d got=%b/%h exp=1/%h", c, fp_out_valid,
        fp_out_data, sbq[0].data); end
    end
    out_ready = 1'b1;
    er = skid ? 4'b0000 : 4'b0100;
    #1;
    total++; if (fp_in_ready !== er) begin bad++;
      $display("FAIL bp_release_in_ready got=%b exp=%b", fp_in_ready, er); end
    if (!skid) sbq.push_back('{sel: 2'd2, data: 32'hBEEF});
    void'(sbq.pop_front());
    tick();
    in_valid = '0;
    it = sbq.pop_front();
    total++; if (fp_out_valid !== 1'b1 || fp_out_data !== it.data) begin bad++;
      $display("FAIL bp_next_word got=%b/%h exp=1/%h", fp_out_valid, fp_out_data, it.data); end
    tick();
    total++; if (fp_out_valid !== 1'b0 || fp_out_data !== it.data) begin bad++;
      $display("FAIL idle_hold got=%b/%h exp=0/%h", fp_out_valid, fp_out_data, it.data); end
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) set_ch(i, 32'hA0 + i);
    in_valid = 4'b0010;
    sbq.push_back('{sel: 2'd1, data: 32'hA1});
    tick();
    it = sbq.pop_front();
    total++; if (rr_out_sel !== it.sel || rr_out_data !== it.data) begin bad++;
      $display("FAIL flush_setup got=%0d/%h exp=%0d/%h", rr_out_sel, rr_out_data,
      it.sel, it.data); end
    out_ready = 1'b0;
    in_valid = '0;
    tick();
    flush = 1'b1;
    in_valid = 4'hF;
    #1;
    total++; if (rr_in_ready !== 4'h0 || fp_in_ready !== 4'h0) begin bad++;
      $display("FAIL flush_in_ready got=%b/%b exp=0000/0000", rr_in_ready, fp_in_ready); end
    tick();
    flush = 1'b0;
    total++; if (rr_out_valid !== 1'b0 || fp_out_valid !== 1'b0) begin bad++;
      $display("FAIL flush_out_valid got=%b/%b exp=0/0", rr_out_valid, fp_out_valid); end
    out_ready = 1'b1;
    sbq.push_back('{sel: 2'd2, data: 32'hA2});
    #1;
    total++; if (rr_in_ready !== 4'b0100) begin bad++;
      $display("FAIL flush_rr_ptr_kept got=%b exp=0100", rr_in_ready); end
    tick();
    in_valid = '0;
    it = sbq.pop_front();
    total++; if (rr_out_valid !== 1'b1 || rr_out_sel !== it.sel || rr_out_data !== it.data)
      begin bad++; $display("FAIL flush_after got=%b/%0d/%h exp=1/%0d/%h", rr_out_valid,
      rr_out_sel, rr_out_data, it.sel, it.data); end
  endtask

  task automatic test_reset_midstall();
    do_reset();
    out_ready = 1'b1;
    set_ch(0, 32'h5A5A);
    in_valid = 4'b0001;
    tick();
    out_ready = 1'b0;
    in_valid = '0;
    tick();
    total++; if (fp_out_valid !== 1'b1 || fp_out_data !== 32'h5A5A) begin bad++;
      $display("FAIL midstall_held got=%b/%h exp=1/5a5a", fp_out_valid, fp_out_data); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (fp_out_valid !== 1'b0 || fp_out_data !== 32'h0) begin bad++;
      $display("FAIL midstall_async got=%b/%h exp=0/0", fp_out_valid, fp_out_data); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    total++; if (fp_out_valid !== 1'b0) begin bad++;
      $display("FAIL midstall_reappear got=%b exp=0", fp_out_valid); end
  endtask

  task automatic test_toggle_stream();
    logic [31:0] val;
    int          got;
    do_reset();
    val = 32'd1;
    got = 0;
    in_valid = 4'b0001;
    for (int c = 0; c < 30; c++) begin
      out_ready = (c % 2 == 0);
      set_ch(0, val);
      #3;
      if (fp_out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL toggle_extra_word got=%h exp=none", fp_out_data);
        end else begin
          it = sbq.pop_front();
          total++; if (fp_out_data !== it.data) begin bad++;
            $display("FAIL toggle_order got=%h exp=%h", fp_out_data, it.data); end
          got++;
        end
      end
      if (fp_in_ready[0]) begin
        sbq.push_back('{sel: 2'd0, data: val});
        val++;
      end
      tick();
    end
    in_valid = '0;
    total++; if (got < 10) begin bad++;
      $display("FAIL toggle_throughput got=%0d exp>=10", got); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_round_robin();
    test_backpressure();
    test_flush();
    test_reset_midstall();
    test_toggle_stream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux_n_stream.md
MUX_N_STREAM -- requirements
Module: mux_n_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of every channel.
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels (legal 2..16).
REQ-003 SHALL have parameter ARB_MODE, default 0, 0 = fixed priority (lowest index wins), 1 = round robin.
REQ-004 SHALL derive SEL_W = max(1, clog2(CHANNELS)) internally.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port flush  input  1  synchronous discard of held output.
REQ-008 SHALL have port in_data  input  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port in_valid  input  CHANNELS  per-channel valid.
REQ-010 SHALL have port in_ready  output  CHANNELS  per-channel ready, one-hot or zero.
REQ-011 SHALL have port out_data  output  WIDTH  registered selected data.
REQ-012 SHALL have port out_sel  output  SEL_W  index of channel that supplied out_data.
REQ-013 SHALL have port out_valid  output  1  out_data/out_sel valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts.

Function
REQ-015 Transfer on a port SHALL occur only in a cycle where its valid and ready are both 1.
REQ-016 load_en SHALL equal (~out_valid | out_ready) & ~flush in the base build.
REQ-017 Grant SHALL go to exactly one requesting channel when load_en=1 and any in_valid=1; in_ready SHALL be grant & load_en.
REQ-018 ARB_MODE=0: grant SHALL be lowest-index asserted in_valid.
REQ-019 ARB_MODE=1: search SHALL start at pointer rr_ptr and wrap modulo CHANNELS; after grant to i, rr_ptr SHALL become (i+1) mod CHANNELS (CHANNELS-1 wraps to 0).
REQ-020 rr_ptr SHALL change only on an accepted transfer; unchanged when idle, stalled or flushed.
REQ-021 On transfer, next cycle out_data SHALL equal granted channel data, out_sel its index, out_valid=1 (latency 1 cycle).
REQ-022 If load_en=1 and no in_valid, out_valid SHALL go 0 next cycle; out_data/out_sel hold.
REQ-023 While out_valid=1 and out_ready=0, out_data/out_sel/out_valid SHALL hold stable and in_ready SHALL be 0.
REQ-024 Simultaneous out_ready=1 and new grant SHALL give back-to-back transfers, one per cycle, no bubble.
REQ-025 flush=1 SHALL force in_ready=0 and clear out_valid next cycle, overriding any out_ready or in_valid.
REQ-026 in_valid asserted by a channel SHALL not be required to stay high; dropped requests are not latched.

Reset
REQ-027 rst_n=0 SHALL asynchronously set out_valid=0, out_data=0, out_sel=0, rr_ptr=0 (and skid state empty if compiled).
REQ-028 in_ready SHALL be 0 while rst_n=0; first grant possible on first clk edge after rst_n deasserts.
REQ-029 Reset mid-stall SHALL discard the held word; it SHALL not reappear.

Configuration
REQ-030 Macro MUX_N_STREAM_SKID_EN SHALL, when defined, add a one-entry skid register so in_ready depends only on registered state (no combinational out_ready->in_ready path).
REQ-031 With MUX_N_STREAM_SKID_EN: load_en = ~skid_valid & ~flush; word accepted while out stalled goes to skid, drained to output when out_ready=1; order preserved; flush clears skid too; latency still 1 cycle.
REQ-032 Without MUX_N_STREAM_SKID_EN: behaviour per REQ-016, no skid storage.

Verification
REQ-033 Reset: rst_n=0 with in_valid=4'hF -> in_ready=0, out_valid=0, out_data=0, out_sel=0.
REQ-034 Priority (ARB_MODE=0, out_ready=1): in_valid=4'b1010, in_data ch1=32'h11, ch3=32'h33 held 3 cycles -> out_data=32'h11, out_sel=1 every cycle; ch3 never granted.
REQ-035 Round robin (ARB_MODE=1, out_ready=1): in_valid=4'hF held 5 cycles -> out_sel sequence 0,1,2,3,0.
REQ-036 Backpressure: one transfer ch2=32'hDEAD, then out_ready=0 for 4 cycles -> out_data=32'hDEAD stable, in_ready=0 (base) throughout; out_ready=1 -> word consumed, next grant following cycle.
REQ-037 Flush: out_valid=1, out_ready=0, flush=1 one cycle -> out_valid=0 next cycle, rr_ptr unchanged, no in_ready asserted that cycle.
REQ-038 Skid build: out_ready toggles 1,0,1,0 with in_valid=4'h1 incrementing data 1,2,3... -> output sequence strictly 1,2,3... with no loss or duplication.
